// File: rtl/conveyor_pkg.sv
// conveyor_pkg: state encoding shared by the conveyor controller.
package conveyor_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FILL = 2'b10,
        DONE = 2'b11
    } state_e;
endpackage

// File: rtl/rise_edge_det.sv
// rise_edge_det: one-cycle pulse on a 0->1 transition of d.
module rise_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);
    logic d_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d;
    end
    assign pulse = d & ~d_q;
endmodule

// File: rtl/conveyor_ctrl_fsm.sv
// conveyor_ctrl_fsm: button/sensor event generation and Moore sequencing of motor and fill valve.
// Batch counting and the DONE state are enabled by defining CONVEYOR_BATCH_COUNT_EN.
module conveyor_ctrl_fsm
    import conveyor_pkg::*;
#(
    parameter int FILL_CYCLES = 50_000_000,
    parameter int BATCH_SIZE  = 12,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_pb,
    input  logic               stop_pb,
    input  logic               bottle_sensor,
    output logic               motor_en,
    output logic               valve_en,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   bottle_cnt,
    output logic               batch_done
);
    localparam int TW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(FILL_CYCLES - 1);

    state_e        state_q, state_d, done_nxt;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          s1_q, s2_q;
    logic          start_evt, stop_evt, bottle_evt, fill_end, last;

    rise_edge_det u_start  (.clk(clk), .rst_n(rst_n), .d(start_pb), .pulse(start_evt));
    rise_edge_det u_stop   (.clk(clk), .rst_n(rst_n), .d(stop_pb),  .pulse(stop_evt));
    rise_edge_det u_bottle (.clk(clk), .rst_n(rst_n), .d(s2_q),     .pulse(bottle_evt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            s1_q    <= bottle_sensor;
            s2_q    <= s1_q;
        end
    end

    // A stop during the last fill cycle aborts the bottle, so it is never counted.
    assign fill_end = (state_q == FILL) && !stop_evt && (tmr_q == '0);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: state_d = (start_evt && !stop_evt) ? RUN : IDLE;
            RUN: begin
                if (stop_evt) state_d = IDLE;
                else if (bottle_evt) begin
                    state_d = FILL;
                    tmr_d   = TLOAD;
                end
            end
            FILL: begin
                if (stop_evt)      state_d = IDLE;
                else if (fill_end) state_d = last ? DONE : RUN;
                else               tmr_d   = tmr_q - 1'b1;
            end
            default: state_d = done_nxt;
        endcase
    end

`ifdef CONVEYOR_BATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    assign cnt_inc  = cnt_q + 1'b1;
    assign last     = (cnt_inc == CNT_W'(BATCH_SIZE));
    assign done_nxt = stop_evt ? IDLE : (start_evt ? RUN : DONE);
    always_comb begin
        cnt_d = cnt_q;
        if (fill_end) cnt_d = cnt_inc;
        if (state_q == DONE && (stop_evt || start_evt)) cnt_d = '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign bottle_cnt = cnt_q;
    assign batch_done = (state_q == DONE);
`else
    logic unused_cfg;
    assign unused_cfg = (BATCH_SIZE == 0);
    assign last       = 1'b0;
    assign done_nxt   = IDLE;
    assign bottle_cnt = '0;
    assign batch_done = 1'b0;
`endif

    assign state_o  = state_q;
    assign motor_en = (state_q == RUN);
    assign valve_en = (state_q == FILL);
endmodule

// File: tb/tb_conveyor_ctrl_fsm.sv
// tb_conveyor_ctrl_fsm: directed and randomized checks of conveyor_ctrl_fsm against a behavioural model.
module tb_conveyor_ctrl_fsm;
    localparam int FC = 4, BS = 3, CW = 8;
`ifdef CONVEYOR_BATCH_COUNT_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b1;
    logic start_pb = 1'b0, stop_pb = 1'b0, bottle_sensor = 1'b0;
    logic motor_en, valve_en, batch_done;
    logic [1:0] state_o;
    logic [CW-1:0] bottle_cnt;
    int checks = 0, failures = 0;

    // Model: line running, batch done, valve cycles remaining, bottles counted, input history.
    bit m_run = 0, m_done = 0;
    int m_fill = 0, m_cnt = 0;
    bit sp = 0, tp = 0, p1 = 0, p2 = 0, p3 = 0;

    always #5 clk = ~clk;

    conveyor_ctrl_fsm #(.FILL_CYCLES(FC), .BATCH_SIZE(BS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start_pb(start_pb), .stop_pb(stop_pb),
        .bottle_sensor(bottle_sensor), .motor_en(motor_en), .valve_en(valve_en),
        .state_o(state_o), .bottle_cnt(bottle_cnt), .batch_done(batch_done)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_fill = 0; m_cnt = 0;
            sp = 0; tp = 0; p1 = 0; p2 = 0; p3 = 0;
        end else begin : step
            bit sev, tev, bev;
            sev = start_pb && !sp;
            tev = stop_pb && !tp;
            bev = p2 && !p3;
            if (m_done) begin
                if (tev || sev) begin
                    m_done = 0;
                    m_cnt  = 0;
                    m_run  = !tev;
                end
            end else if (m_fill > 0) begin
                if (tev) m_fill = 0;
                else begin
                    m_fill--;
                    if (m_fill == 0) begin
                        if (BE) m_cnt++;
                        if (BE && m_cnt == BS) m_done = 1;
                        else m_run = 1;
                    end
                end
            end else if (m_run) begin
                if (tev) m_run = 0;
                else if (bev) begin
                    m_run  = 0;
                    m_fill = FC;
                end
            end else if (sev && !tev) m_run = 1;
            sp = start_pb; tp = stop_pb;
            p3 = p2; p2 = p1; p1 = bottle_sensor;
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0] es;
        logic [12:0] act, exp;
        es  = m_done ? 2'd3 : (m_fill > 0) ? 2'd2 : m_run ? 2'd1 : 2'd0;
        act = {state_o, motor_en, valve_en, batch_done, bottle_cnt};
        exp = {es, m_run, m_fill > 0, m_done, CW'(m_cnt)};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model_compare t=%0t got st=%0d mot=%0b vlv=%0b done=%0b cnt=%0d expected st=%0d mot=%0b vlv=%0b done=%0b cnt=%0d",
                     $time, act[12:11], act[10], act[9], act[8], act[7:0],
                     exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valve(output bit seen);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = valve_en;
        end
    endtask

    task automatic bottle(output int hi);
        bit seen;
        bottle_sensor = 1;
        @(negedge clk);
        bottle_sensor = 0;
        wait_valve(seen);
        hi = 0;
        while (seen && valve_en && hi < 20) begin
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic start_pulse();
        start_pb = 1;
        @(negedge clk);
        start_pb = 0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : main
        int hi;
        bit seen;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {state_o, motor_en, valve_en, batch_done, bottle_cnt}, 0);
        rst_n = 1;

        start_pb = 1;
        @(negedge clk);
        chk("start_first_edge_state", state_o, 1);
        chk("start_first_edge_motor", motor_en, 1);
        repeat (19) @(negedge clk);
        chk("start_held_state", state_o, 1);
        start_pb = 0;

        bottle_sensor = 1;
        @(negedge clk);
        chk("sensor_edge_n", state_o, 1);
        bottle_sensor = 0;
        @(negedge clk);
        chk("sensor_edge_n1", state_o, 1);
        @(negedge clk);
        chk("sensor_edge_n2_state", state_o, 2);
        chk("sensor_edge_n2_valve", valve_en, 1);
        hi = 0;
        while (valve_en && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        chk("fill_length", hi, FC);
        chk("after_fill_state", state_o, 1);
        chk("after_fill_cnt", bottle_cnt, BE ? 1 : 0);

        bottle_sensor = 1;
        @(negedge clk);
        bottle_sensor = 0;
        wait_valve(seen);
        chk("abort_fill_entered", seen, 1);
        @(negedge clk);
        stop_pb = 1;
        @(negedge clk);
        stop_pb = 0;
        chk("abort_state", state_o, 0);
        chk("abort_valve", valve_en, 0);
        chk("abort_cnt", bottle_cnt, BE ? 1 : 0);

        start_pulse();
        chk("resume_state", state_o, 1);
        bottle(hi);
        chk("bottle2_len", hi, FC);
        bottle(hi);
        chk("bottle3_len", hi, FC);
        chk("batch_state", state_o, BE ? 3 : 1);
        chk("batch_done", batch_done, BE ? 1 : 0);
        chk("batch_cnt", bottle_cnt, BE ? 3 : 0);
        bottle(hi);
        chk("bottle_in_done_len", hi, BE ? 0 : FC);
        chk("bottle_in_done_state", state_o, BE ? 3 : 1);
        start_pulse();
        chk("restart_state", state_o, 1);
        chk("restart_cnt", bottle_cnt, 0);
        chk("restart_done", batch_done, 0);

        start_pb = 1;
        stop_pb  = 1;
        @(negedge clk);
        chk("start_stop_same_cycle", state_o, 0);
        start_pb = 0;
        stop_pb  = 0;
        bottle(hi);
        chk("idle_bottle_dropped", hi, 0);
        chk("idle_bottle_state", state_o, 0);

        start_pulse();
        bottle_sensor = 1;
        @(negedge clk);
        bottle_sensor = 0;
        wait_valve(seen);
        chk("reset_fill_entered", seen, 1);
        @(posedge clk);
        #2 rst_n = 0;
        #1 chk("async_reset_outputs", {state_o, motor_en, valve_en, batch_done, bottle_cnt}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) start_pb = ~start_pb;
            stop_pb = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 4) == 0) bottle_sensor = ~bottle_sensor;
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
